// File: rtl/foc_frontend_hls_deadlock_reporter.sv
// Qualifies the dataflow monitor's per-cycle block flag with a persistence threshold and
// presents a snapshot of the stalled channels/instances on a valid/ready report port.
module foc_frontend_hls_deadlock_reporter #(
  parameter int unsigned THRESHOLD = 256,
  parameter int unsigned CNT_W     = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        block,
  input  logic [9:0]  axis_block_sigs,
  input  logic [4:0]  inst_idle_sigs,
  input  logic        clear,
  input  logic        rpt_ready,
  output logic        rpt_valid,
  output logic [9:0]  rpt_axis_sigs,
  output logic [4:0]  rpt_idle_sigs,
  output logic [31:0] rpt_timestamp,
  output logic        deadlock_detected,
  output logic [7:0]  glitch_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SUSPECT = 2'd1,
    REPORT  = 2'd2,
    LATCHED = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESHOLD);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  state_t            state_r;
  logic [CNT_W-1:0]  stall_cnt_r;
  logic [9:0]        acc_axis_r;
  logic [31:0]       ts_r;
  logic [CNT_W-1:0]  stall_next_s;
  logic [9:0]        acc_next_s;

  // Next-cycle stall count and channel accumulation while a window is open
  always_comb begin
    stall_next_s = stall_cnt_r + ONE_C;
    acc_next_s   = acc_axis_r | axis_block_sigs;
  end

  // Free-running timestamp; only reset zeroes it, clear leaves it running
  always_ff @(posedge clock) begin
    if (reset) begin
      ts_r <= 32'd0;
    end else begin
      ts_r <= ts_r + 32'd1;
    end
  end

  // Detection FSM with registered report outputs
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      // clear deliberately shares the reset path; it also wins over a same-cycle handshake
      state_r           <= IDLE;
      stall_cnt_r       <= '0;
      acc_axis_r        <= 10'd0;
      rpt_valid         <= 1'b0;
      rpt_axis_sigs     <= 10'd0;
      rpt_idle_sigs     <= 5'd0;
      rpt_timestamp     <= 32'd0;
      deadlock_detected <= 1'b0;
      glitch_cnt        <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (block) begin
            state_r     <= SUSPECT;
            stall_cnt_r <= ONE_C;
            acc_axis_r  <= axis_block_sigs;
          end else begin
            stall_cnt_r <= '0;
            acc_axis_r  <= 10'd0;
          end
        end
        SUSPECT: begin
          if (block) begin
            if (stall_next_s == THRESH_C) begin
              state_r           <= REPORT;
              stall_cnt_r       <= '0;
              acc_axis_r        <= 10'd0;
              rpt_axis_sigs     <= acc_next_s;
              rpt_idle_sigs     <= inst_idle_sigs;
              rpt_timestamp     <= ts_r;
              rpt_valid         <= 1'b1;
              deadlock_detected <= 1'b1;
            end else begin
              stall_cnt_r <= stall_next_s;
              acc_axis_r  <= acc_next_s;
            end
          end else begin
            state_r     <= IDLE;
            stall_cnt_r <= '0;
            acc_axis_r  <= 10'd0;
            if (glitch_cnt != 8'hFF) begin
              glitch_cnt <= glitch_cnt + 8'd1;
            end else begin
              glitch_cnt <= glitch_cnt;
            end
          end
        end
        REPORT: begin
          if (rpt_ready) begin
            state_r   <= LATCHED;
            rpt_valid <= 1'b0;
          end else begin
            rpt_valid <= 1'b1;
          end
        end
        LATCHED: begin
          deadlock_detected <= 1'b1;
        end
        default: begin
          state_r     <= IDLE;
          stall_cnt_r <= '0;
          acc_axis_r  <= 10'd0;
          rpt_valid   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_foc_frontend_hls_deadlock_reporter.sv
// Directed, table-driven bench for the deadlock reporter with THRESHOLD=8.
module tb_foc_frontend_hls_deadlock_reporter;

  localparam int TH = 8;

  logic        clock = 1'b0;
  logic        reset, block, clear, rpt_ready;
  logic [9:0]  axis_block_sigs;
  logic [4:0]  inst_idle_sigs;
  logic        rpt_valid, deadlock_detected;
  logic [9:0]  rpt_axis_sigs;
  logic [4:0]  rpt_idle_sigs;
  logic [31:0] rpt_timestamp;
  logic [7:0]  glitch_cnt;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] cyc = 32'd0;
  logic [31:0] ts_base = 32'd0;

  typedef struct {
    logic        rst, blk;
    logic [9:0]  ax;
    logic [4:0]  id;
    logic        clr, rdy;
    logic        ev, ed;
    logic [9:0]  eax;
    logic [4:0]  eid;
    logic [7:0]  eg;
    logic [31:0] ets;
  } vec_t;

  vec_t vecs[$];

  foc_frontend_hls_deadlock_reporter #(.THRESHOLD(TH), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .block(block),
    .axis_block_sigs(axis_block_sigs), .inst_idle_sigs(inst_idle_sigs),
    .clear(clear), .rpt_ready(rpt_ready), .rpt_valid(rpt_valid),
    .rpt_axis_sigs(rpt_axis_sigs), .rpt_idle_sigs(rpt_idle_sigs),
    .rpt_timestamp(rpt_timestamp), .deadlock_detected(deadlock_detected),
    .glitch_cnt(glitch_cnt)
  );

  always #5 clock = ~clock;

  // Reference cycle counter: value after an edge equals ts before the next edge
  always @(posedge clock) begin
    if (reset) cyc <= 32'd0;
    else       cyc <= cyc + 32'd1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic b, input logic [9:0] ax, input logic [4:0] id,
                       input logic cl, input logic rd);
    reset = r; block = b; axis_block_sigs = ax; inst_idle_sigs = id; clear = cl; rpt_ready = rd;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic add(input logic r, input logic b, input logic [9:0] ax, input logic [4:0] id,
                     input logic cl, input logic rd, input logic ev, input logic ed,
                     input logic [9:0] eax, input logic [4:0] eid, input logic [7:0] eg,
                     input logic [31:0] ets);
    vec_t v;
    v.rst = r; v.blk = b; v.ax = ax; v.id = id; v.clr = cl; v.rdy = rd;
    v.ev = ev; v.ed = ed; v.eax = eax; v.eid = eid; v.eg = eg; v.ets = ets;
    vecs.push_back(v);
  endtask

  // Opens a full-length window; checks no early report and a report after the last sample
  task automatic run_window(input logic [9:0] a0, input logic [9:0] a1, input logic [4:0] id,
                            input logic rdy, input string tag, output logic [31:0] ts_exp);
    ts_exp = 32'd0;
    for (int k = 0; k < TH; k++) begin
      drive(1'b0, 1'b1, (k % 2 == 0) ? a0 : a1, id, 1'b0, rdy);
      if (k == TH - 1) ts_exp = cyc + ts_base;
      tick();
      if (k < TH - 1) chk({tag, "_early_valid"}, rpt_valid, 1'b0);
    end
    chk({tag, "_valid"}, rpt_valid, 1'b1);
    chk({tag, "_detected"}, deadlock_detected, 1'b1);
    chk({tag, "_ts"}, rpt_timestamp, ts_exp);
  endtask

  initial begin
    logic [31:0] tse;
    logic        bad;
    drive(1'b1, 1'b0, 10'd0, 5'd0, 1'b0, 1'b0);

    // rst blk ax id clr rdy | valid det axis idle glitch ts
    add(1, 0, 10'h000, 5'h00, 0, 0, 0, 0, 10'h000, 5'h00, 8'd0, 32'd0);
    add(0, 0, 10'h000, 5'h00, 0, 0, 0, 0, 10'h000, 5'h00, 8'd0, 32'd0);
    add(0, 1, 10'h010, 5'h00, 0, 0, 0, 0, 10'h000, 5'h00, 8'd0, 32'd0);
    add(0, 1, 10'h010, 5'h00, 0, 0, 0, 0, 10'h000, 5'h00, 8'd0, 32'd0);
    add(0, 1, 10'h010, 5'h00, 0, 0, 0, 0, 10'h000, 5'h00, 8'd0, 32'd0);
    add(0, 0, 10'h000, 5'h00, 0, 0, 0, 0, 10'h000, 5'h00, 8'd1, 32'd0);
    for (int k = 0; k < TH - 1; k++)
      add(0, 1, (k % 2 == 0) ? 10'h001 : 10'h080, 5'h04, 0, 1, 0, 0, 10'h000, 5'h00, 8'd1, 32'd0);
    add(0, 1, 10'h080, 5'h04, 0, 1, 1, 1, 10'h081, 5'h04, 8'd1, 32'd12);
    add(0, 0, 10'h000, 5'h00, 0, 1, 0, 1, 10'h081, 5'h04, 8'd1, 32'd12);
    add(0, 1, 10'h3FF, 5'h1F, 0, 1, 0, 1, 10'h081, 5'h04, 8'd1, 32'd12);
    add(0, 1, 10'h3FF, 5'h1F, 1, 0, 0, 0, 10'h000, 5'h00, 8'd0, 32'd0);
    add(0, 0, 10'h000, 5'h00, 0, 0, 0, 0, 10'h000, 5'h00, 8'd0, 32'd0);
    add(0, 1, 10'h001, 5'h00, 0, 0, 0, 0, 10'h000, 5'h00, 8'd0, 32'd0);
    add(0, 1, 10'h001, 5'h00, 0, 0, 0, 0, 10'h000, 5'h00, 8'd0, 32'd0);
    add(0, 1, 10'h001, 5'h00, 1, 0, 0, 0, 10'h000, 5'h00, 8'd0, 32'd0);
    add(0, 0, 10'h000, 5'h00, 0, 0, 0, 0, 10'h000, 5'h00, 8'd0, 32'd0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].blk, vecs[i].ax, vecs[i].id, vecs[i].clr, vecs[i].rdy);
      tick();
      chk($sformatf("vec%0d_valid", i), rpt_valid, vecs[i].ev);
      chk($sformatf("vec%0d_detected", i), deadlock_detected, vecs[i].ed);
      chk($sformatf("vec%0d_axis", i), rpt_axis_sigs, vecs[i].eax);
      chk($sformatf("vec%0d_idle", i), rpt_idle_sigs, vecs[i].eid);
      chk($sformatf("vec%0d_glitch", i), glitch_cnt, vecs[i].eg);
      chk($sformatf("vec%0d_ts", i), rpt_timestamp, vecs[i].ets);
    end

    // Backpressure: report must hold while the inputs keep moving
    run_window(10'h200, 10'h002, 5'h11, 1'b0, "bp", tse);
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, i[0], 10'(i * 37 + 5), 5'(i), 1'b0, 1'b0);
      tick();
      chk("bp_hold_valid", rpt_valid, 1'b1);
      chk("bp_hold_axis", rpt_axis_sigs, 10'h202);
      chk("bp_hold_idle", rpt_idle_sigs, 5'h11);
      chk("bp_hold_ts", rpt_timestamp, tse);
    end
    drive(1'b0, 1'b1, 10'h3FF, 5'h1F, 1'b0, 1'b1);
    tick();
    chk("bp_ack_valid", rpt_valid, 1'b0);
    chk("bp_ack_detected", deadlock_detected, 1'b1);
    chk("bp_ack_axis", rpt_axis_sigs, 10'h202);
    drive(1'b0, 1'b1, 10'h3FF, 5'h1F, 1'b0, 1'b0);
    repeat (TH + 2) tick();
    chk("latched_ignores_block", rpt_valid, 1'b0);
    chk("latched_sticky", deadlock_detected, 1'b1);

    // Clear abort from REPORT with a simultaneous handshake
    drive(1'b0, 1'b0, 10'h000, 5'h00, 1'b1, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 10'h001, 5'h00, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, 10'h000, 5'h00, 1'b0, 1'b0);
    tick();
    chk("abort_pre_glitch", glitch_cnt, 8'd1);
    run_window(10'h004, 10'h100, 5'h0A, 1'b0, "abort_win", tse);
    chk("abort_win_axis", rpt_axis_sigs, 10'h104);
    chk("abort_win_idle", rpt_idle_sigs, 5'h0A);
    drive(1'b0, 1'b1, 10'h3FF, 5'h1F, 1'b1, 1'b1);
    tick();
    chk("abort_valid", rpt_valid, 1'b0);
    chk("abort_detected", deadlock_detected, 1'b0);
    chk("abort_axis", rpt_axis_sigs, 10'h000);
    chk("abort_idle", rpt_idle_sigs, 5'h00);
    chk("abort_ts", rpt_timestamp, 32'd0);
    chk("abort_glitch", glitch_cnt, 8'd0);
    drive(1'b0, 1'b0, 10'h000, 5'h00, 1'b0, 1'b0);
    tick();
    run_window(10'h008, 10'h008, 5'h03, 1'b1, "fresh", tse);
    chk("fresh_axis", rpt_axis_sigs, 10'h008);
    tick();
    chk("fresh_pulse_end", rpt_valid, 1'b0);

    // Glitch counting with saturation
    drive(1'b0, 1'b0, 10'h000, 5'h00, 1'b1, 1'b0);
    tick();
    bad = 1'b0;
    for (int n = 0; n < 300; n++) begin
      for (int k = 0; k < TH - 1; k++) begin
        drive(1'b0, 1'b1, 10'h040, 5'h02, 1'b0, 1'b1);
        tick();
        if (rpt_valid !== 1'b0) bad = 1'b1;
      end
      drive(1'b0, 1'b0, 10'h000, 5'h00, 1'b0, 1'b1);
      tick();
      if (rpt_valid !== 1'b0) bad = 1'b1;
      if (n == 9)   chk("glitch_10", glitch_cnt, 8'd10);
      if (n == 254) chk("glitch_255", glitch_cnt, 8'd255);
    end
    chk("glitch_no_valid", bad, 1'b0);
    chk("glitch_saturated", glitch_cnt, 8'd255);
    chk("glitch_no_detect", deadlock_detected, 1'b0);

    // Reset mid-window with block held high afterwards
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b1, 10'h020, 5'h01, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 1'b1, 10'h020, 5'h01, 1'b0, 1'b0);
    tick();
    chk("rst_valid", rpt_valid, 1'b0);
    chk("rst_detected", deadlock_detected, 1'b0);
    chk("rst_glitch", glitch_cnt, 8'd0);
    chk("rst_axis", rpt_axis_sigs, 10'h000);
    chk("rst_ts", rpt_timestamp, 32'd0);
    run_window(10'h020, 10'h020, 5'h01, 1'b0, "post_rst", tse);
    chk("post_rst_ts_value", rpt_timestamp, 32'd7);

    // Timestamp wrap: ts before the threshold edge lands on 1
    drive(1'b0, 1'b0, 10'h000, 5'h00, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 10'h000, 5'h00, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b0, 10'h000, 5'h00, 1'b0, 1'b0);
    ts_base = 32'hFFFF_FFFA - cyc;
    force dut.ts_r = 32'hFFFF_FFFA;
    release dut.ts_r;
    run_window(10'h001, 10'h001, 5'h10, 1'b0, "wrap", tse);
    chk("wrap_ts_value", rpt_timestamp, 32'h0000_0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
